// File: rtl/pipelined_segment_adder_pkg.sv
// Shared types and configuration helpers for the segmented pipelined adder.
// Stage records use a fixed maximum width; bits above WIDTH are tied off and pruned.
package pipelined_segment_adder_pkg;

    localparam int MAX_WIDTH  = 64;
    localparam int DEF_WIDTH  = 8;
    localparam int DEF_SEG    = 2;
    localparam int DEF_STAGES = DEF_WIDTH / DEF_SEG;

    function automatic int seg_stages(input int width, input int seg);
        return (seg > 0) ? width / seg : 0;
    endfunction

    function automatic bit seg_cfg_ok(input int width, input int seg);
        return (seg > 0) && (width >= seg) && (width % seg == 0) && (width <= MAX_WIDTH);
    endfunction

    // sum holds completed (deskewed) segments; x/y hold operands still waiting for their carry
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic                 ovf;
        logic [MAX_WIDTH-1:0] sum;
        logic [MAX_WIDTH-1:0] x;
        logic [MAX_WIDTH-1:0] y;
    } stage_t;

endpackage

// File: rtl/pipelined_segment_adder_seg_adder_stage.sv
// One SEG-bit slice of the adder: adds segment IDX with the incoming carry and
// registers the whole stage record, holding it while the pipe is stalled.
module seg_adder_stage
    import pipelined_segment_adder_pkg::*;
#(
    parameter int SEG = 2,
    parameter int IDX = 0
) (
    input  logic   clk1,
    input  logic   rst_n,
    input  logic   advance_i,
    input  stage_t stage_i,
    output stage_t stage_o
);

    localparam int LSB = IDX * SEG;
    localparam int MSB = LSB + SEG - 1;

    logic [SEG:0] seg_sum;
    stage_t       stage_d;
    stage_t       stage_q;

    assign seg_sum = {1'b0, stage_i.x[LSB +: SEG]} + {1'b0, stage_i.y[LSB +: SEG]}
                   + {{SEG{1'b0}}, stage_i.carry};

    always_comb begin
        stage_d                 = stage_i;
        stage_d.sum[LSB +: SEG] = seg_sum[SEG-1:0];
        stage_d.carry           = seg_sum[SEG];
        // carry into the slice MSB is x^y^sum at that bit
        stage_d.ovf             = stage_i.x[MSB] ^ stage_i.y[MSB] ^ seg_sum[SEG-1] ^ seg_sum[SEG];
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else if (advance_i) begin
            stage_q <= stage_d;
        end
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/pipelined_segment_adder.sv
// WIDTH-bit add/subtract split into SEG-bit pipelined slices with a global
// valid/ready stall; results leave only from the last stage register.
module pipelined_segment_adder
    import pipelined_segment_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Carryin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Carryout,
    output logic             Overflow
);

    localparam int STAGES = seg_stages(WIDTH, SEG);

    if (!seg_cfg_ok(WIDTH, SEG)) begin : g_cfg_bad
        $error("pipelined_segment_adder: WIDTH must be a positive multiple of SEG and <= MAX_WIDTH");
    end

    logic             advance;
    logic [WIDTH-1:0] y_eff;
    stage_t           stage_in;
    stage_t           stage_out [STAGES];
    stage_t           last_stage;
    logic             unused_tail;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign y_eff    = Sub ? ~Y : Y;

    always_comb begin
        stage_in       = '0;
        stage_in.valid = in_valid;
        stage_in.carry = Sub | Carryin;
        stage_in.x     = MAX_WIDTH'(X);
        stage_in.y     = MAX_WIDTH'(y_eff);
    end

    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        stage_t stage_src;
        if (gi == 0) begin : g_head
            assign stage_src = stage_in;
        end else begin : g_body
            assign stage_src = stage_out[gi-1];
        end

        seg_adder_stage #(
            .SEG (SEG),
            .IDX (gi)
        ) u_stage (
            .clk1      (clk1),
            .rst_n     (rst_n),
            .advance_i (advance),
            .stage_i   (stage_src),
            .stage_o   (stage_out[gi])
        );
    end

    assign last_stage = stage_out[STAGES-1];
    assign out_valid  = last_stage.valid;
    assign Sum        = last_stage.sum[WIDTH-1:0];
    assign Carryout   = last_stage.carry;
    assign Overflow   = last_stage.ovf;

    // consumed operand bits and padding above WIDTH have no destination
    assign unused_tail = ^{last_stage.x, last_stage.y, last_stage.sum};

endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Directed bench for pipelined_segment_adder in three configurations:
// 8/2 (latency 4), 16/16 (latency 1) and 12/3 (latency 4).
module tb_pipelined_segment_adder;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        ci;
        logic        sb;
        logic [15:0] s;
        logic        c;
        logic        v;
    } vec_t;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        cin;
    logic        sub;
    logic [15:0] x_tb;
    logic [15:0] y_tb;
    int          cfg;

    int n_vec = 0;
    int n_bad = 0;

    vec_t dv [3][7];

    always #5 clk1 = ~clk1;

    logic       iv0, ir0, ov0, c0, v0;
    logic [7:0] s0;
    logic       iv1, ir1, ov1, c1, v1;
    logic [15:0] s1;
    logic       iv2, ir2, ov2, c2, v2;
    logic [11:0] s2;

    assign iv0 = in_valid && (cfg == 0);
    assign iv1 = in_valid && (cfg == 1);
    assign iv2 = in_valid && (cfg == 2);

    pipelined_segment_adder #(.WIDTH(8), .SEG(2)) u_dut0 (
        .clk1(clk1), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
        .X(x_tb[7:0]), .Y(y_tb[7:0]), .Carryin(cin), .Sub(sub),
        .out_valid(ov0), .out_ready(out_ready), .Sum(s0), .Carryout(c0), .Overflow(v0)
    );

    pipelined_segment_adder #(.WIDTH(16), .SEG(16)) u_dut1 (
        .clk1(clk1), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .X(x_tb), .Y(y_tb), .Carryin(cin), .Sub(sub),
        .out_valid(ov1), .out_ready(out_ready), .Sum(s1), .Carryout(c1), .Overflow(v1)
    );

    pipelined_segment_adder #(.WIDTH(12), .SEG(3)) u_dut2 (
        .clk1(clk1), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
        .X(x_tb[11:0]), .Y(y_tb[11:0]), .Carryin(cin), .Sub(sub),
        .out_valid(ov2), .out_ready(out_ready), .Sum(s2), .Carryout(c2), .Overflow(v2)
    );

    logic [15:0] o_sum;
    logic        o_cout, o_ovf, o_valid, o_iready;

    always_comb begin
        o_sum    = {8'd0, s0};
        o_cout   = c0;
        o_ovf    = v0;
        o_valid  = ov0;
        o_iready = ir0;
        case (cfg)
            1: begin
                o_sum = s1; o_cout = c1; o_ovf = v1; o_valid = ov1; o_iready = ir1;
            end
            2: begin
                o_sum = {4'd0, s2}; o_cout = c2; o_ovf = v2; o_valid = ov2; o_iready = ir2;
            end
            default: ;
        endcase
    end

    function automatic int cfg_width(input int c);
        return (c == 0) ? 8 : (c == 1) ? 16 : 12;
    endfunction

    function automatic int cfg_lat(input int c);
        return (c == 1) ? 1 : 4;
    endfunction

    // Reference: plain integer add, overflow from operand/result sign bits
    function automatic logic [17:0] ref_add(input int w, input logic [15:0] x, input logic [15:0] y,
                                            input logic ci, input logic sb);
        logic [16:0] mask, xx, yy, full;
        logic        c, v;
        mask = (17'd1 << w) - 17'd1;
        xx   = {1'b0, x} & mask;
        yy   = sb ? (~{1'b0, y} & mask) : ({1'b0, y} & mask);
        full = xx + yy + {16'd0, (sb ? 1'b1 : ci)};
        c    = full[w];
        v    = (xx[w-1] == yy[w-1]) && (full[w-1] != xx[w-1]);
        return {v, c, full[15:0] & mask[15:0]};
    endfunction

    function automatic vec_t mk(input logic [15:0] x, input logic [15:0] y, input logic ci,
                                input logic sb, input logic [15:0] s, input logic c, input logic v);
        vec_t r;
        r.x = x; r.y = y; r.ci = ci; r.sb = sb; r.s = s; r.c = c; r.v = v;
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cfg=%0d t=%0t: got %0h, expected %0h", tag, cfg, $time, got, exp);
        end else begin
            $display("ok   %s cfg=%0d: %0h", tag, cfg, got);
        end
    endtask

    task automatic run_single(input vec_t vv);
        int lat;
        lat = cfg_lat(cfg);
        @(negedge clk1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        x_tb = vv.x; y_tb = vv.y; cin = vv.ci; sub = vv.sb;
        #1;
        check_val("single_in_ready", 32'(o_iready), 32'd1);
        for (int i = 1; i <= lat; i++) begin
            @(posedge clk1);
            #1;
            if (i == 1) in_valid = 1'b0;
            check_val("single_lat_valid", 32'(o_valid), 32'(i == lat));
        end
        check_val("single_result", 32'({o_ovf, o_cout, o_sum}), 32'({vv.v, vv.c, vv.s}));
        @(posedge clk1);
        #1;
        check_val("single_drained", 32'(o_valid), 32'd0);
    endtask

    task automatic run_stream(input int n, input bit with_stall, input bit no_bubble);
        logic [17:0] exp_q[$];
        logic [17:0] held;
        logic [15:0] mask16, cx, cy;
        logic        cc, cs, stalled_prev;
        int          w, sent, got, cyc;
        w = cfg_width(cfg);
        mask16 = 16'((32'd1 << w) - 32'd1);
        sent = 0; got = 0; cyc = 0; stalled_prev = 1'b0; held = '0;
        cx = 16'($urandom) & mask16; cy = 16'($urandom) & mask16;
        cc = 1'($urandom); cs = 1'($urandom);
        while (got < n && cyc < 300) begin
            @(negedge clk1);
            out_ready = !(with_stall && cyc >= 8 && cyc < 11);
            in_valid  = (sent < n);
            x_tb = cx; y_tb = cy; cin = cc; sub = cs;
            #1;
            if (no_bubble && got > 0)
                check_val("stream_no_bubble", 32'(o_valid), 32'd1);
            if (o_valid && !out_ready) begin
                check_val("stall_in_ready", 32'(o_iready), 32'd0);
                if (stalled_prev)
                    check_val("stall_hold", 32'({o_ovf, o_cout, o_sum}), 32'(held));
                held = {o_ovf, o_cout, o_sum};
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            if (o_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("stream_extra", 32'd1, 32'd0);
                end else begin
                    check_val("stream_result", 32'({o_ovf, o_cout, o_sum}), 32'(exp_q.pop_front()));
                end
                got++;
            end
            if (in_valid && o_iready) begin
                exp_q.push_back(ref_add(w, cx, cy, cc, cs));
                sent++;
                cx = 16'($urandom) & mask16; cy = 16'($urandom) & mask16;
                cc = 1'($urandom); cs = 1'($urandom);
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_val("stream_count", 32'(got), 32'(n));
        check_val("stream_left", 32'(exp_q.size()), 32'd0);
        @(posedge clk1);
        #1;
        check_val("stream_drained", 32'(o_valid), 32'd0);
    endtask

    task automatic run_reset_mid();
        @(negedge clk1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            x_tb = 16'h0123 + 16'(i); y_tb = 16'h0011; cin = 1'b1; sub = 1'b0;
            @(negedge clk1);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk1);
        #1;
        check_val("rst_mid_out_valid", 32'(o_valid), 32'd0);
        check_val("rst_mid_fields", 32'({o_ovf, o_cout, o_sum}), 32'd0);
        check_val("rst_mid_in_ready", 32'(o_iready), 32'd1);
        @(negedge clk1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        run_single(dv[cfg][0]);
    endtask

    initial begin
        dv[0][0] = mk(16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1);
        dv[0][1] = mk(16'h0005, 16'h0007, 1'b0, 1'b1, 16'h00FE, 1'b0, 1'b0);
        dv[0][2] = mk(16'h0080, 16'h0001, 1'b0, 1'b1, 16'h007F, 1'b1, 1'b1);
        dv[0][3] = mk(16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        dv[0][4] = mk(16'h00FF, 16'h00FF, 1'b1, 1'b0, 16'h00FF, 1'b1, 1'b0);
        dv[0][5] = mk(16'h0003, 16'h0003, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        dv[0][6] = mk(16'h0055, 16'h00AA, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0);

        dv[1][0] = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        dv[1][1] = mk(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        dv[1][2] = mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        dv[1][3] = mk(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        dv[1][4] = mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        dv[1][5] = mk(16'h0003, 16'h0003, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        dv[1][6] = mk(16'h5555, 16'hAAAA, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);

        dv[2][0] = mk(16'h07FF, 16'h0001, 1'b0, 1'b0, 16'h0800, 1'b0, 1'b1);
        dv[2][1] = mk(16'h0005, 16'h0007, 1'b0, 1'b1, 16'h0FFE, 1'b0, 1'b0);
        dv[2][2] = mk(16'h0800, 16'h0001, 1'b0, 1'b1, 16'h07FF, 1'b1, 1'b1);
        dv[2][3] = mk(16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        dv[2][4] = mk(16'h0FFF, 16'h0FFF, 1'b1, 1'b0, 16'h0FFF, 1'b1, 1'b0);
        dv[2][5] = mk(16'h0003, 16'h0003, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        dv[2][6] = mk(16'h0555, 16'h0AAA, 1'b0, 1'b0, 16'h0FFF, 1'b0, 1'b0);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cin = 1'b0; sub = 1'b0; x_tb = '0; y_tb = '0; cfg = 0;
        repeat (3) @(posedge clk1);
        #1;
        for (int c = 0; c < 3; c++) begin
            cfg = c;
            #1;
            check_val("reset_out_valid", 32'(o_valid), 32'd0);
            check_val("reset_fields", 32'({o_ovf, o_cout, o_sum}), 32'd0);
            check_val("reset_in_ready", 32'(o_iready), 32'd1);
        end
        @(negedge clk1);
        rst_n = 1'b1;

        for (int c = 0; c < 3; c++) begin
            cfg = c;
            for (int i = 0; i < 7; i++) run_single(dv[c][i]);
            run_stream(20, 1'b0, 1'b1);
            run_stream(20, 1'b1, 1'b0);
            run_reset_mid();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipelined_segment_adder.md
# pipelined_segment_adder

Parametrised, pipelined successor to the single-cycle ripple-carry chain: a WIDTH-bit adder/subtractor split into SEG-bit segments, with one register stage per segment. A valid/ready handshake with backpressure supports one operation per cycle at a fixed latency. It sits in the datapath wherever a wide add no longer closes timing as a flat ripple chain.

## Interface
- WIDTH, 8: operand width in bits; must be an integer multiple of SEG.
- SEG, 2: segment width in bits. STAGES = WIDTH/SEG; STAGES ≥ 1.
- clk1  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  X, Y, Carryin and Sub are valid this cycle.
- in_ready  out  1  block accepts the input this cycle.
- X  in  WIDTH  operand A.
- Y  in  WIDTH  operand B.
- Carryin  in  1  carry into bit 0; ignored when Sub=1.
- Sub  in  1  0 means X+Y+Carryin; 1 means X−Y, computed as X+~Y+1.
- out_valid  out  1  result fields are valid.
- out_ready  in  1  downstream accepts the result.
- Sum  out  WIDTH  result bits [WIDTH-1:0].
- Carryout  out  1  carry out of bit WIDTH-1. For subtraction this is not-borrow.
- Overflow  out  1  two's-complement signed overflow: carry into the MSB XOR Carryout.

## Operation
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Global stall: advance = !out_valid || out_ready. in_ready = advance.
- When advance=0, every pipeline register holds, including valid bits and skew buffers.
- Stage k (0..STAGES-1) adds segment k of X and Y' (Y' = Sub ? ~Y : Y) plus the carry registered by stage k-1.
  - Stage 0 uses Carryin, or 1 when Sub=1.
  - Stage k registers the segment-k sum bits and its carry.
- Operand skew: segment k of X and Y' is delayed k register stages so it meets its carry. Completed sum segments are carried forward (deskewed) so all of Sum emerges in the same cycle.
- Each stage carries a valid bit. Bubbles propagate, and data registers of invalid stages are don't-care internally.
- Output fields are driven from the final stage registers only. No combinational path from inputs to outputs.
- Overflow uses the carry into bit WIDTH-1 from the final stage's internal ripple, XORed with that stage's carry out.
- Arithmetic is modulo 2^WIDTH. Carryout and Overflow are the only extension bits.

## Timing
- Latency: a transfer accepted at edge n appears at out_valid after edge n+STAGES, provided no stall occurs in between. Each stall cycle adds one cycle.
- Throughput: one result per cycle while out_ready=1.
- When STAGES=1, the block degenerates to a registered full-width adder with latency 1.
- Reset (rst_n=0 at an edge):
  - All valid bits clear, so out_valid=0 after that edge.
  - Sum, Carryout and Overflow go to 0.
  - in_ready=1 during reset.
- Reset mid-operation: all in-flight operations are dropped, with no partial result emitted. The first accepted input after reset release sees an empty pipe.
- Simultaneous output transfer and input transfer in the same cycle with a full pipe is legal. The pipe shifts and no bubble is inserted.
- out_valid with out_ready=0:
  - Sum, Carryout and Overflow stay stable until the transfer.
  - in_ready=0 for the whole stall.

## Structure
- The shared package holds:
  - derived constant STAGES = WIDTH/SEG;
  - a compile-time check that WIDTH % SEG == 0, which fails elaboration otherwise;
  - the per-stage record type: valid, carry, deskewed sum, skewed X and Y' remainder.
- Sub-module seg_adder_stage: one SEG-bit combinational add plus its stage registers and hold-on-stall enable. It is instantiated STAGES times in a generate loop, with its carry chained to the next stage.
- Top level: stall logic, Y inversion for Sub, output field mapping.

## Test plan
- WIDTH=8, SEG=2, single op: X=0x7F, Y=0x01, Carryin=0, Sub=0 → after 4 cycles, Sum=0x80, Carryout=0, Overflow=1.
- Subtract: X=0x05, Y=0x07, Sub=1 → Sum=0xFE, Carryout=0, Overflow=0. Then X=0x80, Y=0x01 → Sum=0x7F, Carryout=1, Overflow=1.
- Full carry propagation: X=0xFF, Y=0x00, Carryin=1 → Sum=0x00, Carryout=1.
- Back-to-back streaming: 20 random ops with out_ready=1 → 20 consecutive results matching the reference model, in order, with no bubbles.
- Backpressure: hold out_ready=0 for 3 cycles mid-stream.
  - Outputs and in_ready=0 stay stable.
  - Nothing is lost or duplicated after release.
- Reset mid-stream: assert rst_n=0 with 3 ops in flight.
  - Next cycle: out_valid=0 and Sum=0.
  - After release, the first new op returns at latency 4.
  - Repeat all scenarios with WIDTH=16, SEG=16 (latency 1) and WIDTH=12, SEG=3 (latency 4).
